// File: rtl/hand_draw_scheduler.sv
// hand_draw_scheduler
// Redraws the clock-face hands into a 64x64 framebuffer once per frame_tick
// rising edge. The frame is cleared row by row, then each hand is drawn as
// a run of points at odd radii along the direction returned by a shared
// sin/cos unit.
// Optional feature macro: ALARM_HAND_EN. When it is defined, a fourth (alarm)
// hand is drawn after the second hand. When it is undefined, the frame ends
// after the second hand.
module hand_draw_scheduler #(
  parameter int HOUR_LEN  = 23,
  parameter int MIN_LEN   = 31,
  parameter int SEC_LEN   = 27,
  parameter int ALARM_LEN = 17
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic [8:0]  hour_angle,
  input  logic [8:0]  minute_angle,
  input  logic [8:0]  second_angle,
  input  logic [8:0]  alarm_angle,
  output logic        cordic_start,
  output logic [15:0] cordic_angle,
  input  logic [15:0] cordic_sin,
  input  logic [15:0] cordic_cos,
  input  logic        cordic_done,
  output logic        fb_we,
  output logic        fb_clr,
  output logic [5:0]  fb_x,
  output logic [5:0]  fb_y,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        overrun
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_PLOT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

`ifdef ALARM_HAND_EN
  localparam logic [1:0] LAST_HAND = 2'd3;
`else
  localparam logic [1:0] LAST_HAND = 2'd2;
`endif

  // Index of the last radius step (r = 2k+1) for a given hand.
  function automatic logic [3:0] last_step(input logic [1:0] hand);
    logic [3:0] k;
    case (hand)
      2'd0:    k = 4'((HOUR_LEN - 1) / 2);
      2'd1:    k = 4'((MIN_LEN - 1) / 2);
      2'd2:    k = 4'((SEC_LEN - 1) / 2);
      default: k = 4'((ALARM_LEN - 1) / 2);
    endcase
    return k;
  endfunction

  // trig * radius / 16384, rounded toward zero (magnitude divide, then re-sign).
  function automatic logic signed [21:0] scale_trunc0(input logic [15:0] trig,
                                                      input logic [4:0]  radius);
    logic signed [21:0] prod;
    logic        [21:0] mag;
    logic        [21:0] quo;
    prod = $signed({{6{trig[15]}}, trig}) * $signed({17'd0, radius});
    if (prod[21]) begin
      mag = 22'(-prod);
    end else begin
      mag = 22'(prod);
    end
    quo = mag >> 14;
    if (prod[21]) begin
      return -$signed(quo);
    end else begin
      return $signed(quo);
    end
  endfunction

  // Saturate a signed screen coordinate into the 0..63 range.
  function automatic logic [5:0] clamp_coord(input logic signed [21:0] v);
    logic [5:0] c;
    if (v < 22'sd0) begin
      c = 6'd0;
    end else if (v > 22'sd63) begin
      c = 6'd63;
    end else begin
      c = v[5:0];
    end
    return c;
  endfunction

  state_t      state_r, state_nxt_s;
  logic        tick_d_r;
  logic        tick_edge_s;
  logic [5:0]  cnt_r, cnt_nxt_s;
  logic [1:0]  hand_r, hand_nxt_s;
  logic [8:0]  hour_snap_r, min_snap_r, sec_snap_r, alarm_snap_r;
  logic [8:0]  sel_angle_s;
  logic [15:0] sin_r, cos_r;
  logic        snap_s, latch_s;
  logic [4:0]  radius_s;
  logic [5:0]  plot_x_s, plot_y_s;

  logic        we_nxt_s, clr_nxt_s, start_nxt_s, done_nxt_s;
  logic        busy_nxt_s, overrun_nxt_s;
  logic [5:0]  x_nxt_s, y_nxt_s;
  logic [15:0] angle_nxt_s;

  assign tick_edge_s = frame_tick & ~tick_d_r;
  assign radius_s    = {cnt_r[3:0], 1'b1};
  assign plot_x_s    = clamp_coord(22'sd32 + scale_trunc0(sin_r, radius_s));
  assign plot_y_s    = clamp_coord(22'sd31 - scale_trunc0(cos_r, radius_s));

  // Pick the snapshot angle of the hand currently being drawn.
  always_comb begin
    sel_angle_s = 9'd0;
    case (hand_r)
      2'd0:    sel_angle_s = hour_snap_r;
      2'd1:    sel_angle_s = min_snap_r;
      2'd2:    sel_angle_s = sec_snap_r;
      default: sel_angle_s = alarm_snap_r;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    hand_nxt_s    = hand_r;
    snap_s        = 1'b0;
    latch_s       = 1'b0;
    we_nxt_s      = 1'b0;
    clr_nxt_s     = 1'b0;
    x_nxt_s       = 6'd0;
    y_nxt_s       = 6'd0;
    start_nxt_s   = 1'b0;
    angle_nxt_s   = cordic_angle;
    done_nxt_s    = 1'b0;
    busy_nxt_s    = 1'b0;
    overrun_nxt_s = 1'b0;

    if (tick_edge_s && (state_r != ST_IDLE)) begin
      overrun_nxt_s = 1'b1;
    end else begin
      overrun_nxt_s = 1'b0;
    end

    case (state_r)
      ST_IDLE: begin
        if (tick_edge_s) begin
          snap_s      = 1'b1;
          cnt_nxt_s   = 6'd0;
          hand_nxt_s  = 2'd0;
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        we_nxt_s  = 1'b1;
        clr_nxt_s = 1'b1;
        y_nxt_s   = cnt_r;
        if (cnt_r == 6'd63) begin
          cnt_nxt_s   = 6'd0;
          state_nxt_s = ST_REQ;
        end else begin
          cnt_nxt_s = cnt_r + 6'd1;
        end
      end
      ST_REQ: begin
        start_nxt_s = 1'b1;
        angle_nxt_s = {7'd0, sel_angle_s};
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (cordic_done) begin
          latch_s     = 1'b1;
          cnt_nxt_s   = 6'd0;
          state_nxt_s = ST_PLOT;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_PLOT: begin
        we_nxt_s = 1'b1;
        x_nxt_s  = plot_x_s;
        y_nxt_s  = plot_y_s;
        if (cnt_r == {2'b00, last_step(hand_r)}) begin
          cnt_nxt_s = 6'd0;
          if (hand_r == LAST_HAND) begin
            state_nxt_s = ST_DONE;
          end else begin
            hand_nxt_s  = hand_r + 2'd1;
            state_nxt_s = ST_REQ;
          end
        end else begin
          cnt_nxt_s = cnt_r + 6'd1;
        end
      end
      ST_DONE: begin
        done_nxt_s  = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Busy stays up through the cycle that shows frame_done.
    if ((state_nxt_s != ST_IDLE) || (state_r == ST_DONE)) begin
      busy_nxt_s = 1'b1;
    end else begin
      busy_nxt_s = 1'b0;
    end
  end

  // Tick edge register, counters, angle snapshot and latched sin/cos.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_d_r     <= 1'b0;
      cnt_r        <= 6'd0;
      hand_r       <= 2'd0;
      hour_snap_r  <= 9'd0;
      min_snap_r   <= 9'd0;
      sec_snap_r   <= 9'd0;
      alarm_snap_r <= 9'd0;
      sin_r        <= 16'd0;
      cos_r        <= 16'd0;
    end else begin
      tick_d_r <= frame_tick;
      cnt_r    <= cnt_nxt_s;
      hand_r   <= hand_nxt_s;
      if (snap_s) begin
        hour_snap_r  <= hour_angle;
        min_snap_r   <= minute_angle;
        sec_snap_r   <= second_angle;
        alarm_snap_r <= alarm_angle;
      end
      if (latch_s) begin
        sin_r <= cordic_sin;
        cos_r <= cordic_cos;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_we        <= 1'b0;
      fb_clr       <= 1'b0;
      fb_x         <= 6'd0;
      fb_y         <= 6'd0;
      cordic_start <= 1'b0;
      cordic_angle <= 16'd0;
      frame_busy   <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      fb_we        <= we_nxt_s;
      fb_clr       <= clr_nxt_s;
      fb_x         <= x_nxt_s;
      fb_y         <= y_nxt_s;
      cordic_start <= start_nxt_s;
      cordic_angle <= angle_nxt_s;
      frame_busy   <= busy_nxt_s;
      frame_done   <= done_nxt_s;
      overrun      <= overrun_nxt_s;
    end
  end

endmodule

// File: tb/tb_hand_draw_scheduler.sv
// tb_hand_draw_scheduler
// Randomized bench for hand_draw_scheduler with a behavioural CORDIC and a
// write-sequence reference model built from the drawing rules.
module tb_hand_draw_scheduler;

`ifdef ALARM_HAND_EN
  localparam int NH = 4;
`else
  localparam int NH = 3;
`endif
  localparam int HL = 23, ML = 31, SL = 27, AL = 17;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic [8:0]  hour_angle, minute_angle, second_angle, alarm_angle;
  logic        cordic_start;
  logic [15:0] cordic_angle;
  logic [15:0] cordic_sin, cordic_cos;
  logic        cordic_done;
  logic        fb_we, fb_clr;
  logic [5:0]  fb_x, fb_y;
  logic        frame_busy, frame_done, overrun;

  hand_draw_scheduler dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .hour_angle(hour_angle), .minute_angle(minute_angle),
    .second_angle(second_angle), .alarm_angle(alarm_angle),
    .cordic_start(cordic_start), .cordic_angle(cordic_angle),
    .cordic_sin(cordic_sin), .cordic_cos(cordic_cos), .cordic_done(cordic_done),
    .fb_we(fb_we), .fb_clr(fb_clr), .fb_x(fb_x), .fb_y(fb_y),
    .frame_busy(frame_busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;
  int exp_wr_q[$];
  int exp_ang_q[$];
  int start_seen = 0, done_seen = 0, ovr_seen = 0, wr_seen = 0;
  int cordic_lat = 16;
  int spur_req = 0;
  int rst_gen = 0;

  task automatic check_eq(input string tag, input int got, input int want);
    chk_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Behavioural CORDIC: exact values on the axes, a spread of values elsewhere.
  function automatic int sin_of(input int a);
    int v;
    case (a)
      0, 180: return 0;
      90:     return 16384;
      270:    return -16384;
      default: begin
        v = (a * 40503 + 12345) & 32'hFFFF;
        return (v >= 32768) ? v - 65536 : v;
      end
    endcase
  endfunction

  function automatic int cos_of(input int a);
    int v;
    case (a)
      0:       return 16384;
      180:     return -16384;
      90, 270: return 0;
      default: begin
        v = (a * 22739 + 999) & 32'hFFFF;
        return (v >= 32768) ? v - 65536 : v;
      end
    endcase
  endfunction

  function automatic int clamp63(input int v);
    return (v < 0) ? 0 : ((v > 63) ? 63 : v);
  endfunction

  // Reference model: the full ordered list of framebuffer writes for a frame.
  task automatic build_expect(input int h, input int m, input int s, input int a);
    int ang[4];
    int len[4];
    int sv, cv, sx, cy;
    ang = '{h, m, s, a};
    len = '{HL, ML, SL, AL};
    exp_wr_q.delete();
    exp_ang_q.delete();
    for (int y = 0; y < 64; y++) exp_wr_q.push_back((1 << 12) | (y << 6));
    for (int i = 0; i < NH; i++) begin
      exp_ang_q.push_back(ang[i]);
      sv = sin_of(ang[i]);
      cv = cos_of(ang[i]);
      for (int r = 1; r <= len[i]; r += 2) begin
        sx = (sv * r) / 16384;
        cy = (cv * r) / 16384;
        exp_wr_q.push_back((clamp63(31 - cy) << 6) | clamp63(32 + sx));
      end
    end
  endtask

  // Write scoreboard and event counters.
  always @(negedge clk) begin
    if (reset_n) begin
      if (fb_we) begin
        wr_seen++;
        check_eq("busy_on_write", int'(frame_busy), 1);
        if (exp_wr_q.size() == 0) check_eq("extra_write", 1, 0);
        else check_eq("fb_write", int'({fb_clr, fb_y, fb_x}), exp_wr_q.pop_front());
      end
      if (frame_done) done_seen++;
      if (overrun) ovr_seen++;
    end
  end

  // CORDIC responder, plus a stray cordic_done pulse on request.
  initial begin : cordic_model
    int ang, gen, spur_done;
    spur_done = 0;
    cordic_done = 1'b0;
    cordic_sin = 16'd0;
    cordic_cos = 16'd0;
    forever begin
      @(negedge clk);
      if (reset_n && cordic_start) begin
        start_seen++;
        gen = rst_gen;
        ang = int'(cordic_angle);
        if (exp_ang_q.size() > 0) check_eq("cordic_angle", ang, exp_ang_q.pop_front());
        else check_eq("unexpected_start", 1, 0);
        repeat (cordic_lat - 1) @(negedge clk);
        if (gen == rst_gen) check_eq("angle_hold", int'(cordic_angle), ang);
        cordic_sin = 16'(sin_of(ang));
        cordic_cos = 16'(cos_of(ang));
        cordic_done = 1'b1;
        @(negedge clk);
        cordic_done = 1'b0;
        cordic_sin = 16'h5A5A;
        cordic_cos = 16'hA5A5;
      end else if (spur_req != spur_done) begin
        spur_done++;
        cordic_sin = 16'h7FFF;
        cordic_cos = 16'h8000;
        cordic_done = 1'b1;
        @(negedge clk);
        cordic_done = 1'b0;
      end
    end
  end

  task automatic run_frame(input int h, input int m, input int s, input int a,
                           input bit do_ovr);
    int s0, d0, o0, w0;
    hour_angle = 9'(h); minute_angle = 9'(m); second_angle = 9'(s); alarm_angle = 9'(a);
    build_expect(h, m, s, a);
    s0 = start_seen; d0 = done_seen; o0 = ovr_seen; w0 = wr_seen;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    check_eq("busy_start", int'(frame_busy), 1);
    // Inputs change mid-frame; the snapshot must be used.
    hour_angle = 9'($urandom_range(359, 0)); minute_angle = 9'($urandom_range(359, 0));
    second_angle = 9'($urandom_range(359, 0)); alarm_angle = 9'($urandom_range(359, 0));
    repeat (3) @(negedge clk);
    frame_tick = 1'b0;
    spur_req++;
    if (do_ovr) begin
      for (int i = 0; i < 200 && start_seen == s0; i++) @(negedge clk);
      frame_tick = 1'b1;
      repeat (3) @(negedge clk);
      frame_tick = 1'b0;
    end
    for (int i = 0; i < 3000 && done_seen == d0; i++) @(negedge clk);
    check_eq("frame_done_seen", int'(done_seen > d0), 1);
    @(negedge clk);
    check_eq("busy_end", int'(frame_busy), 0);
    repeat (5) @(negedge clk);
    check_eq("done_count", done_seen - d0, 1);
    check_eq("overrun_count", ovr_seen - o0, do_ovr ? 1 : 0);
    check_eq("start_count", start_seen - s0, NH);
    check_eq("write_count", wr_seen - w0, 64 + ((NH == 4) ? 51 : 42));
    check_eq("left_expected", exp_wr_q.size(), 0);
  endtask

  initial begin
    int w0, w1;
    reset_n = 1'b0;
    frame_tick = 1'b0;
    hour_angle = 9'd0; minute_angle = 9'd0; second_angle = 9'd0; alarm_angle = 9'd0;
    #2;
    check_eq("rst_outputs", int'({fb_we, fb_clr, fb_x, fb_y, cordic_start, cordic_angle,
                                   frame_busy, frame_done, overrun}), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_busy", int'(frame_busy), 0);

    cordic_lat = 16;
    run_frame(0, 0, 0, 0, 1'b0);
    run_frame(90, 0, 180, 270, 1'b0);
    run_frame(270, 90, 0, 180, 1'b0);
    cordic_lat = 16;
    run_frame($urandom_range(359, 0), $urandom_range(359, 0),
              $urandom_range(359, 0), $urandom_range(359, 0), 1'b1);
    for (int f = 0; f < 6; f++) begin
      cordic_lat = $urandom_range(20, 1);
      run_frame($urandom_range(359, 0), $urandom_range(359, 0),
                $urandom_range(359, 0), $urandom_range(359, 0), 1'b0);
    end

    // Reset in the middle of plotting.
    cordic_lat = 8;
    hour_angle = 9'd45; minute_angle = 9'd120; second_angle = 9'd200; alarm_angle = 9'd300;
    build_expect(45, 120, 200, 300);
    w0 = wr_seen;
    @(negedge clk);
    frame_tick = 1'b1;
    repeat (3) @(negedge clk);
    frame_tick = 1'b0;
    for (int i = 0; i < 3000 && wr_seen < w0 + 70; i++) @(negedge clk);
    check_eq("reached_plot", int'(wr_seen >= w0 + 70), 1);
    #2;
    reset_n = 1'b0;
    rst_gen++;
    #1;
    check_eq("midplot_rst_outputs", int'({fb_we, fb_clr, fb_x, fb_y, cordic_start,
                                           cordic_angle, frame_busy, frame_done, overrun}), 0);
    exp_wr_q.delete();
    exp_ang_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    w1 = wr_seen;
    repeat (100) @(negedge clk);
    check_eq("no_write_after_reset", wr_seen - w1, 0);
    check_eq("idle_after_reset", int'({frame_busy, frame_done}), 0);

    cordic_lat = 5;
    run_frame(359, 1, 89, 181, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
